// File: rtl/l1_miss_fill_pkg.sv
// Shared definitions for the L1 miss/fill path: default L1 geometry,
// fill FSM states, and address-split helpers. The helpers work on a
// 64-bit carrier so any address width up to 64 bits can use them;
// callers size-cast the result back to their own width.
package l1_miss_fill_pkg;

  localparam int unsigned L1_ADDR_WIDTH     = 32;
  localparam int unsigned L1_NUM_SETS_LOG   = 6;
  localparam int unsigned L1_NUM_WAYS_LOG   = 2;
  localparam int unsigned L1_LINE_BYTES_LOG = 6;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    LRU,
    WRITE
  } fill_state_e;

  // Clear the byte-offset bits, leaving the line address.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned line_bytes_log);
    return addr & ~((64'd1 << line_bytes_log) - 64'd1);
  endfunction

  // Set index field, right-justified.
  function automatic logic [63:0] addr_set(input logic [63:0] addr,
                                           input int unsigned line_bytes_log,
                                           input int unsigned num_sets_log);
    return (addr >> line_bytes_log) & ((64'd1 << num_sets_log) - 64'd1);
  endfunction

  // Tag field, right-justified.
  function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                           input int unsigned line_bytes_log,
                                           input int unsigned num_sets_log);
    return addr >> (line_bytes_log + num_sets_log);
  endfunction

endpackage

// File: rtl/l1_miss_fill.sv
// Single-outstanding L1 miss handler. Takes one line miss, reads the line
// from memory, asks the cache LRU for a victim way and writes tag + data
// into that way in a single cycle. Repeat misses to the in-flight line are
// absorbed; misses to other lines are back-pressured until the fill ends.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no fill in flight, any miss accepted
//   REQ   | line read request presented, held until mem_req_ready
//   WAIT  | request accepted, waiting for the returned line
//   LRU   | victim lookup strobe to the cache (lru_fill_en)
//   WRITE | victim way valid; tag and data written, fill_done pulses
module l1_miss_fill
  import l1_miss_fill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = L1_ADDR_WIDTH,
  parameter int unsigned NUM_SETS_LOG   = L1_NUM_SETS_LOG,
  parameter int unsigned NUM_WAYS_LOG   = L1_NUM_WAYS_LOG,
  parameter int unsigned LINE_BYTES_LOG = L1_LINE_BYTES_LOG,
  parameter int unsigned TAG_WIDTH      = ADDR_WIDTH - NUM_SETS_LOG - LINE_BYTES_LOG,
  parameter int unsigned LINE_BITS      = 8 << LINE_BYTES_LOG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_en,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  output logic                    miss_ready,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [LINE_BITS-1:0]    mem_rsp_data,
  output logic                    lru_fill_en,
  output logic [NUM_SETS_LOG-1:0] lru_fill_set,
  input  logic [NUM_WAYS_LOG-1:0] lru_fill_way_idx,
  output logic                    update_tag_en,
  output logic [NUM_WAYS_LOG-1:0] update_tag_way_idx,
  output logic [NUM_SETS_LOG-1:0] update_tag_set_idx,
  output logic [TAG_WIDTH-1:0]    update_tag,
  output logic                    update_tag_valid,
  output logic                    update_data_en,
  output logic [NUM_WAYS_LOG-1:0] update_data_way_idx,
  output logic [NUM_SETS_LOG-1:0] update_data_set_idx,
  output logic [LINE_BITS-1:0]    update_data,
  output logic                    fill_done,
  output logic [ADDR_WIDTH-1:0]   fill_done_addr
);

  fill_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   line_q, line_d;
  logic [LINE_BITS-1:0]    data_q, data_d;
  logic                    mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic                    lru_fill_en_q, lru_fill_en_d;
  logic [NUM_SETS_LOG-1:0] lru_fill_set_q, lru_fill_set_d;
  logic                    wr_en_q, wr_en_d;

  logic [ADDR_WIDTH-1:0]   miss_line;
  logic [NUM_SETS_LOG-1:0] line_set;
  logic [TAG_WIDTH-1:0]    line_tag;

  assign miss_line = ADDR_WIDTH'(line_align(64'(miss_addr), LINE_BYTES_LOG));
  assign line_set  = NUM_SETS_LOG'(addr_set(64'(line_q), LINE_BYTES_LOG, NUM_SETS_LOG));
  assign line_tag  = TAG_WIDTH'(addr_tag(64'(line_q), LINE_BYTES_LOG, NUM_SETS_LOG));

  // While a fill is in flight, a miss to the same line is already covered
  // and can be dropped; anything else must wait for IDLE.
  assign miss_ready = (state_q == IDLE) || (miss_line == line_q);

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign lru_fill_en   = lru_fill_en_q;
  assign lru_fill_set  = lru_fill_set_q;

  // The victim way arrives from the cache in the write cycle itself, so it
  // is passed straight through rather than registered.
  assign update_tag_en       = wr_en_q;
  assign update_tag_valid    = wr_en_q;
  assign update_tag_way_idx  = wr_en_q ? lru_fill_way_idx : '0;
  assign update_tag_set_idx  = wr_en_q ? line_set : '0;
  assign update_tag          = wr_en_q ? line_tag : '0;
  assign update_data_en      = wr_en_q;
  assign update_data_way_idx = wr_en_q ? lru_fill_way_idx : '0;
  assign update_data_set_idx = wr_en_q ? line_set : '0;
  assign update_data         = wr_en_q ? data_q : '0;
  assign fill_done           = wr_en_q;
  assign fill_done_addr      = wr_en_q ? line_q : '0;

  // Next-state and next-output computation for the fill sequence.
  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    data_d          = data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    lru_fill_en_d   = 1'b0;
    lru_fill_set_d  = '0;
    wr_en_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_en) begin
          line_d          = miss_line;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = miss_line;
          state_d         = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          mem_req_addr_d  = '0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          data_d         = mem_rsp_data;
          lru_fill_en_d  = 1'b1;
          lru_fill_set_d = line_set;
          state_d        = LRU;
        end
      end
      LRU: begin
        wr_en_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = '0;
        state_d         = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      line_q          <= '0;
      data_q          <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      lru_fill_en_q   <= 1'b0;
      lru_fill_set_q  <= '0;
      wr_en_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      line_q          <= line_d;
      data_q          <= data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      lru_fill_en_q   <= lru_fill_en_d;
      lru_fill_set_q  <= lru_fill_set_d;
      wr_en_q         <= wr_en_d;
    end
  end

endmodule
